mul_div_unit: RTL and testbench

//   Multi-cycle multiply/divide unit of the E stage. Consumes the forwarded operands

---
 rtl/mul_div_unit_pkg.sv | 40 ++++
 rtl/mul_div_unit.sv | 191 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_pkg
// Description : Shared definitions for the E-stage multiply/divide unit:
//               MDUOp encodings, FSM state encodings, counter width and a
//               small helper that classifies the multi-cycle operations.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_unit_pkg;

    // Operation selector driven by the decoder alongside the E-stage instruction.
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    // Two-state controller: waiting for work, or counting down an operation.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Cycle counter width; must hold the largest latency (DIV_CYCLES).
    localparam int unsigned C_CNT_W = 4;

    // True for the operations that occupy the unit for several cycles.
    function automatic logic is_multi_cycle(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage : mul_div_unit_pkg
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle multiply/divide unit of the E stage. Holds the
//               architectural HI/LO registers. MULT/MULTU/DIV/DIVU run for a
//               fixed number of cycles with Busy high, then commit to HI/LO.
//               MTHI/MTLO write HI/LO directly; MFHI/MFLO read them
//               combinationally on Out.
// Ports       :
//   clk      in   1      rising-edge clock
//   reset_n  in   1      asynchronous active-low reset
//   A        in   WIDTH  forwarded rs operand
//   B        in   WIDTH  forwarded rt operand
//   MDUOp    in   4      operation select (see mdu_op_e)
//   Start    in   1      one-cycle launch of MULT/MULTU/DIV/DIVU
//   Req      in   1      flush of the E-stage instruction (discards its effect)
//   Busy     out  1      operation in flight
//   Out      out  WIDTH  HI on MFHI, LO on MFLO, otherwise zero
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       MDUOp,
    input  logic             Start,
    input  logic             Req,
    output logic             Busy,
    output logic [WIDTH-1:0] Out
);

    localparam logic [WIDTH-1:0] C_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mdu_state_e           state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]     a_q,     a_d;
    logic [WIDTH-1:0]     b_q,     b_d;
    mdu_op_e              op_q,    op_d;
    logic [WIDTH-1:0]     hi_q,    hi_d;
    logic [WIDTH-1:0]     lo_q,    lo_d;

    // ------------------------------------------------------------------
    // Datapath: results formed from the latched operands only, so input
    // changes after launch cannot disturb the committed value.
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]     prod_s;
    logic [2*WIDTH-1:0]     prod_u;
    logic [WIDTH-1:0]       b_safe;
    logic signed [WIDTH-1:0] quo_s;
    logic signed [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0]       quo_u;
    logic [WIDTH-1:0]       rem_u;
    logic                   div_by_zero;

    always_comb begin
        prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) *
                 $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

        // A zero divisor never commits; substituting 1 keeps the divider
        // free of undefined values while the op is counting down.
        div_by_zero = (b_q == '0);
        b_safe      = div_by_zero ? WIDTH'(1) : b_q;

        // INT_MIN / -1 overflows a WIDTH-bit signed divide; the defined
        // result is quotient INT_MIN, remainder 0.
        if ((a_q == C_INT_MIN) && (b_q == '1)) begin
            quo_s = $signed(a_q);
            rem_s = '0;
        end else begin
            quo_s = $signed(a_q) / $signed(b_safe);
            rem_s = $signed(a_q) % $signed(b_safe);
        end

        quo_u = a_q / b_safe;
        rem_u = a_q % b_safe;
    end

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    logic start_ok;
    logic op_is_div;

    assign start_ok  = Start && !Req && is_multi_cycle(MDUOp);
    assign op_is_div = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = mdu_op_e'(MDUOp);
                    cnt_d   = op_is_div ? C_CNT_W'(DIV_CYCLES)
                                        : C_CNT_W'(MULT_CYCLES);
                    state_d = ST_RUN;
                end else if (!Req) begin
                    if (MDUOp == MDU_MTHI) hi_d = A;
                    if (MDUOp == MDU_MTLO) lo_d = A;
                end
            end

            ST_RUN: begin
                // Req does not reach here: an accepted op always completes.
                if (cnt_q == C_CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    unique case (op_q)
                        MDU_MULT:  {hi_d, lo_d} = prod_s;
                        MDU_MULTU: {hi_d, lo_d} = prod_u;
                        MDU_DIV: begin
                            if (!div_by_zero) begin
                                lo_d = quo_s;
                                hi_d = rem_s;
                            end
                        end
                        MDU_DIVU: begin
                            if (!div_by_zero) begin
                                lo_d = quo_u;
                                hi_d = rem_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - C_CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MDU_NONE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign Busy = (state_q == ST_RUN);

    always_comb begin
        Out = '0;
        if (MDUOp == MDU_MFHI) Out = hi_q;
        if (MDUOp == MDU_MFLO) Out = lo_q;
    end

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit. Directed steps launch
//               operations, push the expected HI/LO into a scoreboard queue,
//               and pop/compare once Busy drops, reading via MFHI/MFLO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    localparam int C_W = 32;

    logic           clk;
    logic           reset_n;
    logic [C_W-1:0] A;
    logic [C_W-1:0] B;
    logic [3:0]     MDUOp;
    logic           Start;
    logic           Req;
    logic           Busy;
    logic [C_W-1:0] Out;

    typedef struct packed {
        logic [C_W-1:0] hi;
        logic [C_W-1:0] lo;
    } exp_t;

    exp_t           sb[$];
    int             checks = 0;
    int             errors = 0;
    logic [C_W-1:0] m_hi, m_lo;   // bench's view of architectural HI/LO

    mul_div_unit #(
        .WIDTH       (C_W),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .MDUOp   (MDUOp),
        .Start   (Start),
        .Req     (Req),
        .Busy    (Busy),
        .Out     (Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [C_W-1:0] obs,
                         input logic [C_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Independent reference using 64-bit arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [C_W-1:0] a,
                                   input logic [C_W-1:0] b, input logic [C_W-1:0] hi,
                                   input logic [C_W-1:0] lo);
        longint          sa, sbv, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = {hi, lo};
        case (op)
            MDU_MULT:  res = sa * sbv;
            MDU_MULTU: res = ua * ub;
            MDU_DIV: if (b != 0) begin
                q = sa / sbv;
                r = sa % sbv;
                res = {r[31:0], q[31:0]};
            end
            MDU_DIVU: if (b != 0) begin
                uq = ua / ub;
                ur = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
            default: ;
        endcase
        return exp_t'(res);
    endfunction

    task automatic read_hilo(output logic [C_W-1:0] hi, output logic [C_W-1:0] lo);
        MDUOp = MDU_MFHI; #1 hi = Out;
        MDUOp = MDU_MFLO; #1 lo = Out;
        MDUOp = MDU_NONE; #1;
    endtask

    // Called at a falling edge; returns at a falling edge with Busy low.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [C_W-1:0] a, input logic [C_W-1:0] b,
                          input int n_exp, input logic [C_W-1:0] e_hi,
                          input logic [C_W-1:0] e_lo, input bit wiggle,
                          input bit req_mid);
        int             n;
        exp_t           e;
        logic [C_W-1:0] hi, lo;
        A = a; B = b; MDUOp = op; Start = 1'b1;
        sb.push_back('{hi: e_hi, lo: e_lo});
        @(negedge clk);
        Start = 1'b0; MDUOp = MDU_NONE;
        n = 0;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            if (wiggle && n == 1) begin A = ~A; B = B + 32'd7; end
            if (req_mid && n == 2) Req = 1'b1;
            if (n == 3) Req = 1'b0;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, C_W'(n), C_W'(n_exp));
        if (sb.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            read_hilo(hi, lo);
            check({tag, " HI"}, hi, e.hi);
            check({tag, " LO"}, lo, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    initial begin
        logic [C_W-1:0] hi, lo, ra, rb;
        logic [3:0]     rop;
        exp_t           e;

        reset_n = 1'b0; A = '0; B = '0; MDUOp = MDU_NONE; Start = 1'b0; Req = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("reset Busy", C_W'(Busy), 32'd0);
        read_hilo(hi, lo);
        check("reset HI", hi, 32'd0);
        check("reset LO", lo, 32'd0);

        // Directed arithmetic
        run_op("MULT -2*3",   MDU_MULT,  32'hFFFF_FFFE, 32'd3, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
        run_op("MULTU max*2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5,
               32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("DIV -7/2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);

        // MTHI / MTLO
        A = 32'h0000_CAFE; MDUOp = MDU_MTHI;
        @(negedge clk);
        A = 32'h0000_BEEF; MDUOp = MDU_MTLO;
        @(negedge clk);
        MDUOp = MDU_NONE;
        read_hilo(hi, lo);
        check("MTHI write", hi, 32'h0000_CAFE);
        check("MTLO write", lo, 32'h0000_BEEF);
        m_hi = hi; m_lo = lo;

        // Divide by zero: full latency, HI/LO preserved
        run_op("DIVU 7/0", MDU_DIVU, 32'd7, 32'd0, 10, m_hi, m_lo, 1'b0, 1'b0);

        // Start with Req: discarded
        A = 32'd9; B = 32'd9; MDUOp = MDU_MULT; Start = 1'b1; Req = 1'b1;
        @(negedge clk);
        Start = 1'b0; Req = 1'b0; MDUOp = MDU_NONE;
        check("Start+Req Busy", C_W'(Busy), 32'd0);
        read_hilo(hi, lo);
        check("Start+Req HI", hi, m_hi);
        check("Start+Req LO", lo, m_lo);

        // MDUOp without Start: no launch
        MDUOp = MDU_DIV; A = 32'd100; B = 32'd3;
        @(negedge clk);
        MDUOp = MDU_NONE;
        check("op without Start Busy", C_W'(Busy), 32'd0);

        // MTLO with Req: discarded
        A = 32'h0000_1234; MDUOp = MDU_MTLO; Req = 1'b1;
        @(negedge clk);
        MDUOp = MDU_NONE; Req = 1'b0;
        read_hilo(hi, lo);
        check("MTLO+Req LO", lo, m_lo);

        // Signed overflow corner
        run_op("DIV min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);

        // Operand latching and Req during RUN
        run_op("MULT latch", MDU_MULT, 32'd5, 32'd6, 5,
               32'd0, 32'd30, 1'b1, 1'b0);
        run_op("MULT req_mid", MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
               32'd0, 32'd1, 1'b0, 1'b1);

        // Model-driven mix
        for (int i = 0; i < 6; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom;
            rb  = (i == 2) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 9)) : $urandom);
            e   = model(rop, ra, rb, m_hi, m_lo);
            run_op($sformatf("mix%0d op%0d", i, rop), rop, ra, rb,
                   (rop <= 4'd2) ? 5 : 10, e.hi, e.lo, 1'b0, 1'b0);
        end

        // Make HI/LO non-zero before the async reset
        run_op("MULTU pre-reset", MDU_MULTU, 32'h0001_0000, 32'h0003_0005, 5,
               32'h0000_0003, 32'h0005_0000, 1'b0, 1'b0);

        // Async reset in the middle of a DIV
        A = 32'd100; B = 32'd7; MDUOp = MDU_DIV; Start = 1'b1;
        sb.push_back('{hi: 32'd2, lo: 32'd14});
        @(negedge clk);
        Start = 1'b0; MDUOp = MDU_MFHI;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async reset Busy", C_W'(Busy), 32'd0);
        check("async reset HI", Out, 32'd0);
        MDUOp = MDU_MFLO; #1;
        check("async reset LO", Out, 32'd0);
        MDUOp = MDU_NONE;
        sb.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("MULT post-reset", MDU_MULT, 32'd7, 32'd6, 5,
               32'd0, 32'd42, 1'b0, 1'b0);

        check("Out idle zero", Out, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mul_div_unit
`default_nettype wire
